// File: rtl/gray_merge_pkg.sv
// Shared types and widths for the gray merge scheduler and its weight ramp.
package gray_merge_pkg;

    localparam int unsigned PIX_W      = 8;
    localparam int unsigned DIM_W      = 12;
    localparam int unsigned TOTAL_W    = 24;
    localparam int unsigned WEIGHT_SUM = 256;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/merge_weight_ramp.sv
// Holds weight1 for the merger: loads an initial value and steps toward a target
// once per frame, landing exactly on the target. weight2 is its complement to 256.
module merge_weight_ramp
    import gray_merge_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PIX_W-1:0] init,
    input  logic             step_en,
    input  logic [PIX_W-1:0] target,
    input  logic [PIX_W-1:0] step,
    output logic [PIX_W-1:0] w1,
    output logic [PIX_W-1:0] w2
);

    logic [PIX_W-1:0] w1_d;

    // Move by step, but never past the target in either direction.
    always_comb begin
        w1_d = w1;
        if (load) begin
            w1_d = init;
        end else if (step_en) begin
            if (w1 < target) begin
                w1_d = ((target - w1) <= step) ? target : (w1 + step);
            end else if (w1 > target) begin
                w1_d = ((w1 - target) <= step) ? target : (w1 - step);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w1 <= init;
            w2 <= PIX_W'(WEIGHT_SUM - 32'(init));
        end else begin
            w1 <= w1_d;
            w2 <= PIX_W'(WEIGHT_SUM - 32'(w1_d));
        end
    end

endmodule

// File: rtl/gray_merge_scheduler.sv
// Frame sequencer for gray_weighted_merger: pairs two gray streams, issues pixels,
// tracks in-flight results with a timeout, and ramps the weights between frames.
module gray_merge_scheduler
    import gray_merge_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned TIMEOUT      = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic [PIX_W-1:0] cfg_w_init,
    input  logic [PIX_W-1:0] cfg_w_end,
    input  logic [PIX_W-1:0] cfg_w_step,
    input  logic             cfg_load,
    input  logic             s1_valid,
    output logic             s1_ready,
    input  logic [PIX_W-1:0] s1_data,
    input  logic             s2_valid,
    output logic             s2_ready,
    input  logic [PIX_W-1:0] s2_data,
    output logic             m_data1_valid,
    output logic             m_data2_valid,
    output logic [PIX_W-1:0] m_gray1,
    output logic [PIX_W-1:0] m_gray2,
    output logic [PIX_W-1:0] m_weight1,
    output logic [PIX_W-1:0] m_weight2,
    input  logic             m_out_valid,
    output logic             busy,
    output logic             frame_done,
    output logic             err_timeout
);

    localparam int unsigned INF_W = 4;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    state_t             state, state_d;
    logic [INF_W-1:0]   inflight, inflight_d;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [TOTAL_W-1:0] pix_cnt, last_idx;
    logic [PIX_W-1:0]   w_end, w_step;
    logic               issue, ret, abort, start_acc, active;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, issue decision and in-flight bookkeeping.
    always_comb begin
        state_d    = state;
        issue      = 1'b0;
        start_acc  = 1'b0;
        active     = (state == RUN) || (state == DRAIN);
        ret        = m_out_valid && (inflight != '0);
        abort      = active && (inflight != '0) && !m_out_valid &&
                     (tmo_cnt == TMO_W'(TIMEOUT - 1));
        case (state)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                issue = s1_valid && s2_valid && !abort && !rst &&
                        (inflight < INF_W'(MAX_INFLIGHT));
                if (abort) begin
                    state_d = IDLE;
                end else if (issue && (pix_cnt == last_idx)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Drained once the last outstanding result returns (or none remain).
                if (abort) begin
                    state_d = IDLE;
                end else if (inflight == INF_W'(ret)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        inflight_d = inflight;
        if (abort) begin
            inflight_d = '0;
        end else if (issue && !ret) begin
            inflight_d = inflight + INF_W'(1);
        end else if (ret && !issue) begin
            inflight_d = inflight - INF_W'(1);
        end
    end

    assign s1_ready = issue;
    assign s2_ready = issue;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight      <= '0;
            tmo_cnt       <= '0;
            pix_cnt       <= '0;
            last_idx      <= '0;
            w_end         <= '0;
            w_step        <= '0;
            m_data1_valid <= 1'b0;
            m_data2_valid <= 1'b0;
            m_gray1       <= '0;
            m_gray2       <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            inflight      <= inflight_d;
            m_data1_valid <= issue;
            m_data2_valid <= issue;
            busy          <= (state_d == RUN) || (state_d == DRAIN);
            frame_done    <= (state_d == DONE);
            if (issue) begin
                m_gray1 <= s1_data;
                m_gray2 <= s2_data;
                pix_cnt <= pix_cnt + TOTAL_W'(1);
            end
            if (start_acc) begin
                last_idx    <= TOTAL_W'(cfg_width) * TOTAL_W'(cfg_height) - TOTAL_W'(1);
                pix_cnt     <= '0;
                w_end       <= cfg_w_end;
                w_step      <= cfg_w_step;
                err_timeout <= 1'b0;
            end
            if (abort) begin
                err_timeout <= 1'b1;
            end
            // Counts only silent cycles while results are owed.
            if (abort || m_out_valid || !active || (inflight == '0)) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end

    merge_weight_ramp u_ramp (
        .clk     (clk),
        .rst     (rst),
        .load    (cfg_load && (state == IDLE)),
        .init    (cfg_w_init),
        .step_en (state == DONE),
        .target  (w_end),
        .step    (w_step),
        .w1      (m_weight1),
        .w2      (m_weight2)
    );

endmodule
